// File: rtl/module_keypad_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : module_keypad_reader_if
// Description : Keypad-side bundle: matrix rows/columns, clear request and
//               decoded key / digit outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface module_keypad_reader_if;
    logic [3:0]  row_i;
    logic        clr_i;
    logic [3:0]  col_o;
    logic [3:0]  key_o;
    logic        key_valid_o;
    logic        pressed_o;
    logic [15:0] digits_o;

    // slave: the keypad reader itself
    modport slave (
        input  row_i, clr_i,
        output col_o, key_o, key_valid_o, pressed_o, digits_o
    );

    // master: whatever drives the keypad and consumes the digits
    modport master (
        output row_i, clr_i,
        input  col_o, key_o, key_valid_o, pressed_o, digits_o
    );
endinterface
`default_nettype wire

// File: rtl/module_keypad_reader.sv
`default_nettype none
// ============================================================================
// Module      : module_keypad_reader
// Description : 4x4 matrix keypad scanner with press/release debounce, hex
//               key encoding and a four-digit shift register.
// Revision    : 1.0 - initial release
// ============================================================================
module module_keypad_reader #(
    parameter int SCAN_CYCLES     = 50000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    module_keypad_reader_if.slave bus
);

    localparam int c_scan_w = $clog2(SCAN_CYCLES);
    localparam int c_deb_w  = $clog2(DEBOUNCE_CYCLES);

    localparam logic [c_scan_w-1:0] c_scan_last = c_scan_w'(SCAN_CYCLES - 1);
    localparam logic [c_scan_w-1:0] c_scan_one  = c_scan_w'(1);
    localparam logic [c_deb_w-1:0]  c_deb_last  = c_deb_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_deb_w-1:0]  c_deb_one   = c_deb_w'(1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_scan_w-1:0]   r_scan_cnt;
    logic [c_deb_w-1:0]    r_deb_cnt;
    logic [3:0]            r_row_meta;
    logic [3:0]            r_row_s;
    logic [3:0]            r_col;
    logic [1:0]            r_col_idx;
    logic [1:0]            r_row_idx;
    logic [3:0]            r_key;
    logic                  r_key_valid;
    logic                  r_pressed;
    logic [15:0]           r_digits;

    logic                  w_any_low;
    logic [1:0]            w_row_sel;
    logic                  w_row_bit;
    logic [3:0]            w_code;
    logic [3:0]            w_col_next;

    function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // Lowest-index active row wins when several keys share a column.
    always_comb begin
        w_row_sel = 2'd3;
        if (!r_row_s[0]) begin
            w_row_sel = 2'd0;
        end else if (!r_row_s[1]) begin
            w_row_sel = 2'd1;
        end else if (!r_row_s[2]) begin
            w_row_sel = 2'd2;
        end
    end

    assign w_any_low  = ~&r_row_s;
    assign w_row_bit  = r_row_s[r_row_idx];
    assign w_code     = keymap(r_row_idx, r_col_idx);
    assign w_col_next = {r_col[2:0], r_col[3]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_SCAN;
            r_scan_cnt  <= '0;
            r_deb_cnt   <= '0;
            r_row_meta  <= 4'hF;
            r_row_s     <= 4'hF;
            r_col       <= 4'b1110;
            r_col_idx   <= 2'd0;
            r_row_idx   <= 2'd0;
            r_key       <= 4'h0;
            r_key_valid <= 1'b0;
            r_pressed   <= 1'b0;
            r_digits    <= 16'h0000;
        end else begin
            r_row_meta  <= bus.row_i;
            r_row_s     <= r_row_meta;
            r_key_valid <= 1'b0;

            if (bus.clr_i) begin
                r_digits <= 16'h0000;
            end

            case (r_state)
                ST_SCAN: begin
                    if (r_scan_cnt == c_scan_last) begin
                        r_scan_cnt <= '0;
                        if (w_any_low) begin
                            r_row_idx <= w_row_sel;
                            r_deb_cnt <= '0;
                            r_state   <= ST_DEBOUNCE;
                        end else begin
                            r_col     <= w_col_next;
                            r_col_idx <= r_col_idx + 2'd1;
                        end
                    end else begin
                        r_scan_cnt <= r_scan_cnt + c_scan_one;
                    end
                end

                ST_DEBOUNCE: begin
                    if (w_row_bit) begin
                        r_state    <= ST_SCAN;
                        r_scan_cnt <= '0;
                        r_col      <= w_col_next;
                        r_col_idx  <= r_col_idx + 2'd1;
                    end else if (r_deb_cnt == c_deb_last) begin
                        r_key       <= w_code;
                        r_key_valid <= 1'b1;
                        r_pressed   <= 1'b1;
                        r_state     <= ST_HOLD;
                        // A coincident clear still keeps the freshly accepted key.
                        if (bus.clr_i) begin
                            r_digits <= {12'h000, w_code};
                        end else begin
                            r_digits <= {r_digits[11:0], w_code};
                        end
                    end else begin
                        r_deb_cnt <= r_deb_cnt + c_deb_one;
                    end
                end

                ST_HOLD: begin
                    if (w_row_bit) begin
                        r_deb_cnt <= '0;
                        r_state   <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    if (!w_row_bit) begin
                        r_state <= ST_HOLD;
                    end else if (r_deb_cnt == c_deb_last) begin
                        r_pressed  <= 1'b0;
                        r_state    <= ST_SCAN;
                        r_scan_cnt <= '0;
                        r_col      <= w_col_next;
                        r_col_idx  <= r_col_idx + 2'd1;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + c_deb_one;
                    end
                end

                default: begin
                    r_state <= ST_SCAN;
                end
            endcase
        end
    end

    assign bus.col_o       = r_col;
    assign bus.key_o       = r_key;
    assign bus.key_valid_o = r_key_valid;
    assign bus.pressed_o   = r_pressed;
    assign bus.digits_o    = r_digits;

endmodule
`default_nettype wire

// File: tb/tb_module_keypad_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_module_keypad_reader
// Description : Self-checking bench: a virtual 4x4 keypad driven by the
//               column outputs, with a digit/key model and timing checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_module_keypad_reader;

    localparam int SCAN = 4;
    localparam int DEB  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    module_keypad_reader_if bus();

    module_keypad_reader #(
        .SCAN_CYCLES    (SCAN),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    // Held keys, index row*4+col; a row reads low when a held key sits in the driven column.
    logic [15:0] held = 16'h0000;
    logic [3:0]  w_row;
    always_comb begin
        w_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (held[r*4+c] && bus.col_o[c] == 1'b0) w_row[r] = 1'b0;
    end
    assign bus.row_i = w_row;

    logic [3:0] kmap [0:3][0:3] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    int         vectors    = 0;
    int         miscompares = 0;
    int         pulses     = 0;
    int         since      = 0;
    logic [3:0] prev_col   = 4'hF;
    bit         prev_ok    = 1'b0;
    bit         seen_change = 1'b0;
    bit         chk_int    = 1'b0;
    logic [15:0] m_dig     = 16'h0000;
    logic [3:0]  m_key     = 4'h0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] colmask(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c);
    endfunction

    function automatic int colidx(input logic [3:0] m);
        for (int i = 0; i < 4; i++)
            if (m == colmask(i)) return i;
        return -1;
    endfunction

    // One clock: sample at the falling edge, count pulses, verify column rotation.
    task automatic tick();
        @(negedge clk);
        if (bus.key_valid_o === 1'b1) pulses++;
        since++;
        if (rst) begin
            prev_ok = 1'b0;
        end else begin
            if (prev_ok && bus.col_o !== prev_col) begin
                check("col_rotate", {12'h000, bus.col_o},
                      {12'h000, colmask((colidx(prev_col) + 1) % 4)});
                if (chk_int && seen_change) check("col_dwell", 16'(since), 16'(SCAN));
                seen_change = 1'b1;
                since = 0;
            end
            prev_col = bus.col_o;
            prev_ok  = 1'b1;
        end
    endtask

    task automatic wait_col(input int c, input bit want_eq);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if ((bus.col_o == colmask(c)) == want_eq) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("wait_col", 16'(ok), 16'd1);
    endtask

    // Press key (r,c) (plus optional same-column key r2), hold, optionally glitch, release.
    task automatic press(input int r, input int c, input int r2, input int hold_n,
                         input bit clr_acc, input bit glitch);
        logic [3:0] code;
        int rr, n, p0;
        rr   = (r2 >= 0 && r2 < r) ? r2 : r;
        code = kmap[rr][c];
        wait_col(c, 1'b0);
        held = 16'h0000;
        held[r*4+c] = 1'b1;
        if (r2 >= 0) held[r2*4+c] = 1'b1;
        p0 = pulses;
        wait_col(c, 1'b1);
        n = 0;
        while (n < 64) begin
            if (clr_acc && n == SCAN + DEB - 1) bus.clr_i = 1'b1;
            tick();
            n++;
            if (bus.key_valid_o === 1'b1) break;
        end
        bus.clr_i = 1'b0;
        check("accept_latency", 16'(n), 16'(SCAN + DEB));
        m_key = code;
        m_dig = clr_acc ? {12'h000, code} : {m_dig[11:0], code};
        check("key_o", {12'h000, bus.key_o}, {12'h000, m_key});
        check("digits_o", bus.digits_o, m_dig);
        check("pressed_on", 16'(bus.pressed_o), 16'd1);
        tick();
        check("valid_one_cycle", 16'(bus.key_valid_o), 16'd0);
        repeat (hold_n) tick();
        if (glitch) begin
            held = 16'h0000;
            repeat (3) tick();
            held[r*4+c] = 1'b1;
            repeat (15) tick();
            check("glitch_pressed", 16'(bus.pressed_o), 16'd1);
            check("glitch_col_hold", {12'h000, bus.col_o}, {12'h000, colmask(c)});
        end
        check("pulse_count", 16'(pulses - p0), 16'd1);
        held = 16'h0000;
        repeat (2 + DEB) tick();
        check("release_pressed_hold", 16'(bus.pressed_o), 16'd1);
        tick();
        check("release_pressed_fall", 16'(bus.pressed_o), 16'd0);
    endtask

    initial begin
        int p0, r, c, r2;
        bus.clr_i = 1'b0;

        // reset state
        repeat (3) tick();
        check("rst_col", {12'h000, bus.col_o}, 16'h000E);
        check("rst_key", {12'h000, bus.key_o}, 16'h0000);
        check("rst_valid", 16'(bus.key_valid_o), 16'd0);
        check("rst_pressed", 16'(bus.pressed_o), 16'd0);
        check("rst_digits", bus.digits_o, 16'h0000);
        rst = 1'b0;

        // idle scanning
        p0 = pulses;
        chk_int = 1'b1;
        seen_change = 1'b0;
        repeat (40) tick();
        chk_int = 1'b0;
        check("idle_no_pulse", 16'(pulses - p0), 16'd0);
        check("idle_digits", bus.digits_o, 16'h0000);

        // single key '5', hold 30, release 30
        press(1, 1, -1, 30, 1'b0, 1'b0);
        repeat (20) tick();
        check("key5_digits", bus.digits_o, 16'h0005);

        // sequence 1 A 0 D, then F
        press(0, 0, -1, 3, 1'b0, 1'b0);
        press(0, 3, -1, 3, 1'b0, 1'b0);
        press(3, 1, -1, 3, 1'b0, 1'b0);
        press(3, 3, -1, 3, 1'b0, 1'b0);
        check("seq_digits", bus.digits_o, 16'h1A0D);
        press(3, 2, -1, 3, 1'b0, 1'b0);
        check("seq_digits_f", bus.digits_o, 16'hA0DF);
        check("seq_key_f", {12'h000, bus.key_o}, 16'h000F);

        // press bounce on '5'
        p0 = pulses;
        wait_col(1, 1'b0);
        wait_col(1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            held = ((i / 3) % 2 == 0) ? 16'h0020 : 16'h0000;
            tick();
        end
        held = 16'h0000;
        repeat (20) tick();
        check("bounce_no_pulse", 16'(pulses - p0), 16'd0);
        check("bounce_pressed", 16'(bus.pressed_o), 16'd0);
        check("bounce_digits", bus.digits_o, m_dig);

        // release glitch on '9'
        press(2, 2, -1, 4, 1'b0, 1'b1);

        // reset in the middle of debouncing '2'
        wait_col(1, 1'b0);
        held = 16'h0002;
        wait_col(1, 1'b1);
        repeat (6) tick();
        p0 = pulses;
        rst = 1'b1;
        #1;
        check("midrst_col", {12'h000, bus.col_o}, 16'h000E);
        check("midrst_key", {12'h000, bus.key_o}, 16'h0000);
        check("midrst_valid", 16'(bus.key_valid_o), 16'd0);
        check("midrst_pressed", 16'(bus.pressed_o), 16'd0);
        check("midrst_digits", bus.digits_o, 16'h0000);
        m_dig = 16'h0000;
        m_key = 4'h0;
        held  = 16'h0000;
        repeat (2) tick();
        rst = 1'b0;
        repeat (30) tick();
        check("midrst_no_pulse", 16'(pulses - p0), 16'd0);

        // clear coincident with acceptance of '7'
        press(0, 2, -1, 2, 1'b0, 1'b0);
        press(2, 0, -1, 2, 1'b1, 1'b0);
        check("clr_acc_digits", bus.digits_o, 16'h0007);

        // plain clear leaves key_o alone
        press(1, 3, -1, 2, 1'b0, 1'b0);
        bus.clr_i = 1'b1;
        tick();
        bus.clr_i = 1'b0;
        m_dig = 16'h0000;
        check("clr_digits", bus.digits_o, m_dig);
        check("clr_key", {12'h000, bus.key_o}, {12'h000, m_key});

        // random keys, sometimes with a second key lower in the same column
        for (int k = 0; k < 24; k++) begin
            r  = int'($urandom_range(0, 3));
            c  = int'($urandom_range(0, 3));
            r2 = -1;
            if (r > 0 && $urandom_range(0, 2) == 0) r2 = int'($urandom_range(0, r - 1));
            press(r, c, r2, int'($urandom_range(1, 10)), 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
